kbd_spi_ctrl: RTL
=================

KBD_SPI_CTRL -- requirements
Module: kbd_spi_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, number of clk cycles allowed between sck edges inside a frame.
REQ-003 clk  input  1  system clock; the only clock in the block; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sck  input  1  external SPI clock, asynchronous to clk.
REQ-006 mosi  input  1  external SPI data, asynchronous to clk.
REQ-007 cs_n  input  1  external SPI chip select, active-low, asynchronous to clk.
REQ-008 key  output  16  keyboard register value as read by the CPU; zero means no key held.
REQ-009 key_strobe  output  1  one-clk pulse whenever key is written by a valid frame.
REQ-010 frame_err  output  1  one-clk pulse per rejected frame.
REQ-011 err_count  output  8  count of rejected frames, saturating at 255.
REQ-012 busy  output  1  high while state is SHIFT or ABORT.

Function
REQ-013 sck, mosi and cs_n SHALL each pass through a SYNC_STAGES-deep synchronizer; all logic uses only synchronized copies.
REQ-014 A rising sck edge SHALL be detected as synchronized sck high while its previous registered value is low; falling edges are ignored.
REQ-015 States: WAIT_IDLE, IDLE, SHIFT, CHECK, ABORT.
REQ-016 WAIT_IDLE -> IDLE when synchronized cs_n is high; no frame can start until this happens.
REQ-017 IDLE -> SHIFT on synchronized cs_n falling; bit counter and shift register cleared to 0.
REQ-018 In SHIFT each rising sck edge SHALL shift synchronized mosi into bit 0 of a 16-bit shift register (MSB first) and increment a 5-bit bit counter, saturating at 17.
REQ-019 In SHIFT a cycle counter SHALL clear on every rising sck edge and increment otherwise; reaching TIMEOUT_CYCLES -> ABORT with frame_err pulse.
REQ-020 SHIFT -> CHECK on synchronized cs_n rising; if a rising sck edge and cs_n rising are detected in the same cycle, the sck edge SHALL be discarded.
REQ-021 CHECK (one cycle) -> IDLE; frame accepted only if bit counter == 16, otherwise rejected.
REQ-022 Accepted frame decode on shift register {cmd[15:8], code[7:0]}: cmd 0x00 -> key = 0x0000 with key_strobe; cmd 0xAA -> key = {8'h00, code} with key_strobe; cmd 0xFF -> keepalive, key unchanged, no strobe, no error; any other cmd -> rejected.
REQ-023 key_strobe SHALL assert in the cycle after CHECK, coincident with the new key value being visible.
REQ-024 Rejected frame: frame_err pulses one cycle after CHECK (or on timeout entry to ABORT), key unchanged, err_count increments unless already 255.
REQ-025 ABORT -> IDLE when synchronized cs_n is high; sck edges in ABORT are ignored.
REQ-026 key_strobe and frame_err SHALL never assert in the same cycle.
REQ-027 Latency from synchronized cs_n rising to key_strobe SHALL be exactly 2 clk cycles.

Reset
REQ-028 On rst_n low, asynchronously: state WAIT_IDLE, key = 0x0000, key_strobe = 0, frame_err = 0, err_count = 0, busy = 0, shift register, bit counter, timeout counter and all synchronizer flops cleared (synchronizer cs_n flops set to 1).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without error count; after release the block waits in WAIT_IDLE if cs_n is still low.
REQ-030 Deassertion of rst_n is assumed synchronous to clk externally; no internal reset synchronizer.

Verification
REQ-031 cs_n low, 16 clocks with mosi=1, cs_n high -> no key_strobe, no frame_err, key stays 0x0000, err_count 0.
REQ-032 frame 0xAA41 (cmd press, code 'A') -> key = 0x0041 with one key_strobe 2 clk after synchronized cs_n rise; then frame 0x0000 -> key = 0x0000 with strobe.
REQ-033 frame of 15 bits, then frame of 17 bits, then 0x5512 -> three frame_err pulses, err_count = 3, key unchanged.
REQ-034 cs_n low, 3 sck edges, then sck idle for TIMEOUT_CYCLES -> frame_err, busy stays high until cs_n high, following valid 0xAA0D frame -> key = 0x000D.
REQ-035 rst_n pulsed low after 8 bits of 0xAA41 with cs_n held low, remaining 8 bits sent -> no strobe, no error; next full 0xAA41 frame -> key = 0x0041.
REQ-036 256 consecutive invalid frames -> err_count = 255 and holds; sck rising edge coincident with cs_n rising on the 16th bit -> that bit discarded, frame rejected.

Source files
------------

// File: rtl/kbd_spi_ctrl.sv
// ============================================================================
// Module   : kbd_spi_ctrl
// Brief    : SPI-slave keyboard register, oversampled by clk, with frame checks
// Revision : 1.0
// ============================================================================
`default_nettype none

module kbd_spi_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        mosi,
    input  logic        cs_n,
    output logic [15:0] key,
    output logic        key_strobe,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int             TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     SETTLE_MAX = 3'(SYNC_STAGES);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CHECK     = 3'd3,
        ST_ABORT     = 3'd4
    } state_t;

    state_t                 state_q,      state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q,   sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q,  mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,    cs_sync_d;
    logic                   sck_prev_q,   sck_prev_d;
    logic                   cs_prev_q,    cs_prev_d;
    logic [2:0]             settle_q,     settle_d;
    logic [15:0]            shreg_q,      shreg_d;
    logic [4:0]             bitcnt_q,     bitcnt_d;
    logic [TO_W-1:0]        tocnt_q,      tocnt_d;
    logic [15:0]            key_q,        key_d;
    logic                   strobe_q,     strobe_d;
    logic                   ferr_q,       ferr_d;
    logic [7:0]             errcnt_q,     errcnt_d;

    logic w_sck_s, w_mosi_s, w_cs_s;
    logic w_sck_rise, w_cs_fall, w_cs_rise;
    logic w_reject;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        w_sck_s     = sck_sync_q[SYNC_STAGES-1];
        w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        w_cs_s      = cs_sync_q[SYNC_STAGES-1];
        sck_prev_d  = w_sck_s;
        cs_prev_d   = w_cs_s;
        w_sck_rise  = w_sck_s & ~sck_prev_q;
        w_cs_fall   = ~w_cs_s & cs_prev_q;
        w_cs_rise   = w_cs_s & ~cs_prev_q;
        // The cs_n chain is preset high, so it only tells the truth once flushed.
        settle_d    = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 3'd1;
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        tocnt_d  = tocnt_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        errcnt_d = errcnt_q;
        w_reject = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (settle_q == SETTLE_MAX && w_cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = 16'h0000;
                    bitcnt_d = 5'd0;
                    tocnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                // A cs_n rise wins over a simultaneous sck edge.
                if (w_cs_rise) begin
                    state_d = ST_CHECK;
                end else if (w_sck_rise) begin
                    shreg_d = {shreg_q[14:0], w_mosi_s};
                    if (bitcnt_q != 5'd17) begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                    tocnt_d = '0;
                end else if (tocnt_q == TO_LAST) begin
                    state_d  = ST_ABORT;
                    w_reject = 1'b1;
                end else begin
                    tocnt_d = tocnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (bitcnt_q == 5'd16) begin
                    case (shreg_q[15:8])
                        8'h00: begin
                            key_d    = 16'h0000;
                            strobe_d = 1'b1;
                        end
                        8'hAA: begin
                            key_d    = {8'h00, shreg_q[7:0]};
                            strobe_d = 1'b1;
                        end
                        8'hFF: ;
                        default: w_reject = 1'b1;
                    endcase
                end else begin
                    w_reject = 1'b1;
                end
            end
            ST_ABORT: begin
                if (w_cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (w_reject) begin
            ferr_d = 1'b1;
            if (errcnt_q != 8'hFF) begin
                errcnt_d = errcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_IDLE;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= 3'd0;
            shreg_q     <= 16'h0000;
            bitcnt_q    <= 5'd0;
            tocnt_q     <= '0;
            key_q       <= 16'h0000;
            strobe_q    <= 1'b0;
            ferr_q      <= 1'b0;
            errcnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            settle_q    <= settle_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            tocnt_q     <= tocnt_d;
            key_q       <= key_d;
            strobe_q    <= strobe_d;
            ferr_q      <= ferr_d;
            errcnt_q    <= errcnt_d;
        end
    end

    assign key        = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = ferr_q;
    assign err_count  = errcnt_q;
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_ABORT);

endmodule

`default_nettype wire
